alu_issue: RTL

ALU_ISSUE -- requirements
Module: alu_issue

---
 rtl/alu_pkg.sv | 52 +++++
 rtl/alu_issue_decode.sv | 143 ++++++++++++++
 rtl/alu_issue.sv | 131 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes, RV32I opcode/funct constants, default widths
// and the RV32I instruction field layout.
package alu_pkg;

  localparam int unsigned WORDSIZE_DEF = 32;
  localparam int unsigned OPSIZE_DEF   = 4;
  localparam int unsigned IMMSIZE_DEF  = 20;

  // ALU op codes
  localparam int unsigned ALU_NONE = 0;
  localparam int unsigned ALU_ADD  = 1;
  localparam int unsigned ALU_SUB  = 2;
  localparam int unsigned ALU_SLL  = 3;
  localparam int unsigned ALU_SRL  = 4;
  localparam int unsigned ALU_SRA  = 5;
  localparam int unsigned ALU_SLU  = 6;
  localparam int unsigned ALU_SLT  = 7;
  localparam int unsigned ALU_OR   = 8;
  localparam int unsigned ALU_AND  = 9;
  localparam int unsigned ALU_XOR  = 10;
  localparam int unsigned ALU_SIU  = 11;

  // RV32I major opcodes
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } rv_instr_t;

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational RV32I decode into ALU operands, op code, destination and
// write-back/illegal flags.
module alu_issue_decode import alu_pkg::*; #(
  parameter int unsigned WORDSIZE = WORDSIZE_DEF,
  parameter int unsigned OPSIZE   = OPSIZE_DEF,
  parameter int unsigned IMMSIZE  = IMMSIZE_DEF
) (
  input  logic [31:0]         instr,
  input  logic [WORDSIZE-1:0] rs1_val,
  input  logic [WORDSIZE-1:0] rs2_val,
  output logic [WORDSIZE-1:0] alu_a_c,
  output logic [WORDSIZE-1:0] alu_b_c,
  output logic [OPSIZE-1:0]   alu_op_c,
  output logic [4:0]          rd_c,
  output logic                wb_en_c,
  output logic                illegal_c
);

  rv_instr_t           f;
  logic [11:0]         imm_i;
  logic [11:0]         imm_s;
  logic [WORDSIZE-1:0] sext_i;
  logic [WORDSIZE-1:0] sext_s;
  logic [WORDSIZE-1:0] zext_sh;
  logic [WORDSIZE-1:0] zext_u;
  logic                unused_rs1;

  logic [OPSIZE-1:0]   op;
  logic [WORDSIZE-1:0] a;
  logic [WORDSIZE-1:0] b;
  logic [4:0]          rd_v;
  logic                wb;
  logic                bad;

  assign f          = rv_instr_t'(instr);
  assign imm_i      = instr[31:20];
  assign imm_s      = {instr[31:25], instr[11:7]};
  assign sext_i     = {{(WORDSIZE-12){imm_i[11]}}, imm_i};
  assign sext_s     = {{(WORDSIZE-12){imm_s[11]}}, imm_s};
  assign zext_sh    = WORDSIZE'(f.rs2);
  assign zext_u     = WORDSIZE'(instr[31 -: IMMSIZE]);
  assign unused_rs1 = ^f.rs1;

  // Register-register funct3 map shared by OP and OP-IMM
  function automatic logic [OPSIZE-1:0] base_op(input logic [2:0] funct3);
    case (funct3)
      F3_ADD:  base_op = OPSIZE'(ALU_ADD);
      F3_SLL:  base_op = OPSIZE'(ALU_SLL);
      F3_SLT:  base_op = OPSIZE'(ALU_SLT);
      F3_SLTU: base_op = OPSIZE'(ALU_SLU);
      F3_XOR:  base_op = OPSIZE'(ALU_XOR);
      F3_SR:   base_op = OPSIZE'(ALU_SRL);
      F3_OR:   base_op = OPSIZE'(ALU_OR);
      default: base_op = OPSIZE'(ALU_AND);
    endcase
  endfunction

  always_comb begin
    op   = OPSIZE'(ALU_NONE);
    a    = '0;
    b    = '0;
    rd_v = '0;
    wb   = 1'b0;
    bad  = 1'b0;
    case (f.opcode)
      OPC_OP_IMM: begin
        a    = rs1_val;
        b    = sext_i;
        rd_v = f.rd;
        wb   = 1'b1;
        op   = base_op(f.funct3);
        // Shift-immediates carry shamt in rs2 and a variant selector in funct7
        if (f.funct3 == F3_SLL || f.funct3 == F3_SR) begin
          b = zext_sh;
          if (f.funct3 == F3_SR && f.funct7 == F7_ALT) op = OPSIZE'(ALU_SRA);
          else if (f.funct7 != F7_BASE)                bad = 1'b1;
        end
      end
      OPC_OP: begin
        a    = rs1_val;
        b    = rs2_val;
        rd_v = f.rd;
        wb   = 1'b1;
        if (f.funct7 == F7_BASE) begin
          op = base_op(f.funct3);
        end else if (f.funct7 == F7_ALT && f.funct3 == F3_ADD) begin
          op = OPSIZE'(ALU_SUB);
        end else if (f.funct7 == F7_ALT && f.funct3 == F3_SR) begin
          op = OPSIZE'(ALU_SRA);
        end else begin
          bad = 1'b1;
        end
      end
      OPC_LUI: begin
        op   = OPSIZE'(ALU_SIU);
        a    = zext_u;
        rd_v = f.rd;
        wb   = 1'b1;
      end
      OPC_LOAD: begin
        op   = OPSIZE'(ALU_ADD);
        a    = rs1_val;
        b    = sext_i;
        rd_v = f.rd;
        wb   = 1'b1;
        bad  = (f.funct3 == 3'b011) || (f.funct3 == 3'b110) || (f.funct3 == 3'b111);
      end
      OPC_STORE: begin
        op  = OPSIZE'(ALU_ADD);
        a   = rs1_val;
        b   = sext_s;
        bad = (f.funct3 > 3'b010);
      end
      OPC_BRANCH: begin
        a = rs1_val;
        b = rs2_val;
        case (f.funct3)
          3'b000, 3'b001: op = OPSIZE'(ALU_SUB);
          3'b100, 3'b101: op = OPSIZE'(ALU_SLT);
          3'b110, 3'b111: op = OPSIZE'(ALU_SLU);
          default:        bad = 1'b1;
        endcase
      end
      default: bad = 1'b1;
    endcase
    // Illegal entries still issue, but carry nothing usable
    if (bad) begin
      op   = OPSIZE'(ALU_NONE);
      a    = '0;
      b    = '0;
      rd_v = '0;
      wb   = 1'b0;
    end
  end

  assign alu_a_c   = a;
  assign alu_b_c   = b;
  assign alu_op_c  = op;
  assign rd_c      = rd_v;
  assign wb_en_c   = wb && (rd_v != 5'd0);
  assign illegal_c = bad;

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: decode plus valid/ready storage. Defining ALU_ISSUE_SKID_EN
// selects a two-entry skid buffer with a registered in_ready.
module alu_issue import alu_pkg::*; #(
  parameter int unsigned WORDSIZE = WORDSIZE_DEF,
  parameter int unsigned OPSIZE   = OPSIZE_DEF,
  parameter int unsigned IMMSIZE  = IMMSIZE_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         instr,
  input  logic [WORDSIZE-1:0] rs1_val,
  input  logic [WORDSIZE-1:0] rs2_val,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WORDSIZE-1:0] alu_a,
  output logic [WORDSIZE-1:0] alu_b,
  output logic [OPSIZE-1:0]   alu_op,
  output logic [4:0]          rd,
  output logic                wb_en,
  output logic                illegal
);

  localparam int unsigned PAY_W = 2 * WORDSIZE + OPSIZE + 5 + 2;

  logic [WORDSIZE-1:0] dec_a;
  logic [WORDSIZE-1:0] dec_b;
  logic [OPSIZE-1:0]   dec_op;
  logic [4:0]          dec_rd;
  logic                dec_wb;
  logic                dec_ill;
  logic [PAY_W-1:0]    dec_pay;

  logic [PAY_W-1:0]    out_q;
  logic                out_valid_q;
  logic                rdy_q;
  logic                in_fire;

  alu_issue_decode #(
    .WORDSIZE (WORDSIZE),
    .OPSIZE   (OPSIZE),
    .IMMSIZE  (IMMSIZE)
  ) u_decode (
    .instr     (instr),
    .rs1_val   (rs1_val),
    .rs2_val   (rs2_val),
    .alu_a_c   (dec_a),
    .alu_b_c   (dec_b),
    .alu_op_c  (dec_op),
    .rd_c      (dec_rd),
    .wb_en_c   (dec_wb),
    .illegal_c (dec_ill)
  );

  assign dec_pay = {dec_a, dec_b, dec_op, dec_rd, dec_wb, dec_ill};
  assign {alu_a, alu_b, alu_op, rd, wb_en, illegal} = out_q;
  assign out_valid = out_valid_q;

`ifdef ALU_ISSUE_SKID_EN

  logic [PAY_W-1:0] skid_q;
  logic             skid_valid_q;
  logic [PAY_W-1:0] out_d;
  logic [PAY_W-1:0] skid_d;
  logic             out_valid_d;
  logic             skid_valid_d;

  assign in_ready = rdy_q;
  assign in_fire  = in_valid && rdy_q;

  // Skid slot drains first to preserve order; in_ready is never set while it is full
  always_comb begin
    out_d        = out_q;
    skid_d       = skid_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    if (!out_valid_q || out_ready) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = in_fire;
        if (in_fire) out_d = dec_pay;
      end
    end else if (in_fire) begin
      skid_d       = dec_pay;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      rdy_q        <= 1'b0;
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      rdy_q        <= !skid_valid_d;
    end
  end

`else

  // rdy_q only gates in_ready off until the first edge out of reset
  assign in_ready = rdy_q && (!out_valid_q || out_ready);
  assign in_fire  = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      rdy_q       <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      if (!out_valid_q || out_ready) begin
        out_valid_q <= in_fire;
        if (in_fire) out_q <= dec_pay;
      end
    end
  end

`endif

endmodule
